// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: key codes, scan FSM states and the row/column keymap.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'b0000;
    localparam logic [3:0] KEY_1    = 4'b0001;
    localparam logic [3:0] KEY_2    = 4'b0010;
    localparam logic [3:0] KEY_3    = 4'b0011;
    localparam logic [3:0] KEY_4    = 4'b0100;
    localparam logic [3:0] KEY_5    = 4'b0101;
    localparam logic [3:0] KEY_6    = 4'b0110;
    localparam logic [3:0] KEY_7    = 4'b0111;
    localparam logic [3:0] KEY_8    = 4'b1000;
    localparam logic [3:0] KEY_9    = 4'b1001;
    localparam logic [3:0] KEY_A    = 4'b1010;
    localparam logic [3:0] KEY_B    = 4'b1011;
    localparam logic [3:0] KEY_PLUS = 4'b1100;
    localparam logic [3:0] KEY_D    = 4'b1101;
    localparam logic [3:0] KEY_EQ   = 4'b1110;
    localparam logic [3:0] KEY_CLR  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } kp_state_e;

    // Indexed by {row, col}; listed from row 3 col 3 down to row 0 col 0.
    localparam logic [15:0][3:0] KEYMAP = {
        KEY_A,    KEY_EQ, KEY_0,  KEY_CLR,
        KEY_B,    KEY_9,  KEY_8,  KEY_7,
        KEY_D,    KEY_6,  KEY_5,  KEY_4,
        KEY_PLUS, KEY_3,  KEY_2,  KEY_1
    };

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key output toward the calculator.
interface keypad_scanner_if;
    logic [3:0] row_out;
    logic [3:0] col_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row_out, key_code, key_valid, key_held,
        input  col_in
    );

    modport slave (
        input  row_out, key_code, key_valid, key_held,
        output col_in
    );
endinterface

// File: rtl/keypad_scanner_keymap.sv
// Maps one row slot's active-high column sample to a key code, with single/multi hit flags.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [1:0] i_row,
    input  logic [3:0] i_col,
    output logic [3:0] o_code,
    output logic       o_hit,
    output logic       o_multi
);

    logic [2:0] w_n;
    logic [1:0] w_col_idx;

    always_comb begin
        w_n       = '0;
        w_col_idx = '0;
        for (int c = 0; c < 4; c++) begin
            if (i_col[c]) begin
                w_n       = w_n + 3'd1;
                w_col_idx = 2'(c);
            end
        end
        o_code  = KEYMAP[{i_row, w_col_idx}];
        o_hit   = (w_n == 3'd1);
        o_multi = (w_n > 3'd1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column synchronizer, per-frame ghost rejection,
// press/release debounce and a single-pulse key report.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_N);

    logic [3:0]       r_col_s1, r_col_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [1:0]       r_acc_n;
    logic [3:0]       r_acc_code;

    kp_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [3:0]       r_cand, w_cand_nx;
    logic [3:0]       r_key_code;
    logic             r_key_valid, r_key_held;

    logic             w_slot_end, w_frame_end;
    logic [3:0]       w_slot_code;
    logic             w_slot_hit, w_slot_multi;
    logic [1:0]       w_base_n, w_acc_n_nx;
    logic [3:0]       w_acc_code_nx;
    logic             w_res_valid, w_same, w_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= kp.col_in;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_slot_end  = (r_div == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_row == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_row <= '0;
        end else if (w_slot_end) begin
            r_div <= '0;
            r_row <= r_row + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign kp.row_out = row_drive(r_row);

    keypad_keymap u_keymap (
        .i_row   (r_row),
        .i_col   (~r_col_s2),
        .o_code  (w_slot_code),
        .o_hit   (w_slot_hit),
        .o_multi (w_slot_multi)
    );

    // Hit count per frame saturates at 2: anything beyond one key is a ghost/chord.
    always_comb begin
        w_base_n      = (r_row == 2'd0) ? 2'd0 : r_acc_n;
        w_acc_n_nx    = w_base_n;
        w_acc_code_nx = r_acc_code;
        if (w_slot_multi) begin
            w_acc_n_nx = 2'd2;
        end else if (w_slot_hit) begin
            if (w_base_n == 2'd0) begin
                w_acc_n_nx    = 2'd1;
                w_acc_code_nx = w_slot_code;
            end else begin
                w_acc_n_nx = 2'd2;
            end
        end
    end

    assign w_res_valid = (w_acc_n_nx == 2'd1);
    assign w_same      = w_res_valid && (w_acc_code_nx == r_cand);
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_n    <= '0;
            r_acc_code <= '0;
        end else if (w_slot_end) begin
            r_acc_n    <= w_acc_n_nx;
            r_acc_code <= w_acc_code_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_pulse    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_res_valid) begin
                        w_state_nx = ST_DEBOUNCE;
                        w_cnt_nx   = CNT_W'(1);
                        w_cand_nx  = w_acc_code_nx;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_res_valid) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else if (!w_same) begin
                        w_cnt_nx  = CNT_W'(1);
                        w_cand_nx = w_acc_code_nx;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_nx = ST_HELD;
                        w_cnt_nx   = '0;
                        w_pulse    = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!w_same) begin
                        w_state_nx = ST_RELEASE;
                        w_cnt_nx   = CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (w_same) begin
                        w_state_nx = ST_HELD;
                        w_cnt_nx   = '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= KEY_CLR;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= w_pulse;
            if (w_pulse) r_key_code <= r_cand;
            r_key_held  <= (w_state_nx == ST_HELD) || (w_state_nx == ST_RELEASE);
        end
    end

    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=3 (16-cycle frames).
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Pressed-key matrix, bit r*4+c; columns pulled low only on the driven row.
    logic [15:0] keys;
    logic [3:0]  w_col;
    always_comb begin
        w_col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kp.row_out[r]) w_col = w_col & ~keys[r*4 +: 4];
    end
    assign kp.col_in = w_col;

    int n_chk = 0, n_fail = 0;
    int n_pulse = 0, n_wide = 0, cyc = 0, pulse_cyc = 0;
    logic [3:0] last_code = 4'h0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kp.key_valid) begin
            n_pulse++;
            last_code = kp.key_code;
            pulse_cyc = cyc;
            if (prev_valid) n_wide++;
        end
        prev_valid = kp.key_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] rot_exp [4];
    int base, base2, t0;

    initial begin
        rot_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys = '0;
        rst  = 1'b1;
        wait_cyc(3);
        chk("rst_row",   32'(kp.row_out),   32'(4'b1110));
        chk("rst_code",  32'(kp.key_code),  32'(KEY_CLR));
        chk("rst_valid", 32'(kp.key_valid), 32'd0);
        chk("rst_held",  32'(kp.key_held),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(4);
            chk("row_rot", 32'(kp.row_out), 32'(rot_exp[i]));
        end

        // '+' held for 10 frames
        base = n_pulse;
        t0   = cyc;
        keys[3] = 1'b1;
        wait_cyc(160);
        chk("plus_pulses", 32'(n_pulse - base), 32'd1);
        chk("plus_code",   32'(last_code), 32'(KEY_PLUS));
        chk("plus_lat",    32'((pulse_cyc - t0) <= 67), 32'd1);
        chk("plus_held",   32'(kp.key_held), 32'd1);
        keys[3] = 1'b0;
        wait_cyc(16);
        chk("plus_held_rel1", 32'(kp.key_held), 32'd1);
        wait_cyc(64);
        chk("plus_held_rel5", 32'(kp.key_held), 32'd0);
        chk("plus_code_keep", 32'(kp.key_code), 32'(KEY_PLUS));
        chk("plus_no_repeat", 32'(n_pulse - base), 32'd1);

        // '5' bouncing every 5 cycles, then stable
        base = n_pulse;
        for (int i = 0; i < 6; i++) begin
            keys[5] = ~keys[5];
            wait_cyc(5);
        end
        keys[5] = 1'b1;
        wait_cyc(128);
        chk("bounce_pulses", 32'(n_pulse - base), 32'd1);
        chk("bounce_code",   32'(last_code), 32'(KEY_5));
        keys[5] = 1'b0;
        wait_cyc(80);
        chk("bounce_held", 32'(kp.key_held), 32'd0);

        // '1' and '2' together: ghost rejection until '2' lets go
        base = n_pulse;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        wait_cyc(96);
        chk("ghost_pulses", 32'(n_pulse - base), 32'd0);
        chk("ghost_held",   32'(kp.key_held), 32'd0);
        keys[1] = 1'b0;
        wait_cyc(80);
        chk("ghost_rel_pulses", 32'(n_pulse - base), 32'd1);
        chk("ghost_rel_code",   32'(last_code), 32'(KEY_1));
        keys[0] = 1'b0;
        wait_cyc(80);
        chk("ghost_end_held", 32'(kp.key_held), 32'd0);

        // '=' with reset mid-debounce, key kept down
        base = n_pulse;
        keys[14] = 1'b1;
        wait_cyc(32);
        chk("eq_pre_rst", 32'(n_pulse - base), 32'd0);
        rst = 1'b1;
        wait_cyc(3);
        chk("eq_rst_code", 32'(kp.key_code), 32'(KEY_CLR));
        chk("eq_rst_held", 32'(kp.key_held), 32'd0);
        rst = 1'b0;
        wait_cyc(96);
        chk("eq_pulses", 32'(n_pulse - base), 32'd1);
        chk("eq_code",   32'(last_code), 32'(KEY_EQ));
        keys[14] = 1'b0;
        wait_cyc(80);

        // '0' twice with a full release between, then a too-short release
        base = n_pulse;
        keys[13] = 1'b1;
        wait_cyc(96);
        keys[13] = 1'b0;
        wait_cyc(64);
        keys[13] = 1'b1;
        wait_cyc(96);
        chk("zero_pulses", 32'(n_pulse - base), 32'd2);
        chk("zero_code",   32'(last_code), 32'(KEY_0));
        base2 = n_pulse;
        keys[13] = 1'b0;
        wait_cyc(32);
        keys[13] = 1'b1;
        wait_cyc(64);
        chk("zero_short_pulses", 32'(n_pulse - base2), 32'd0);
        chk("zero_short_held",   32'(kp.key_held), 32'd1);
        keys[13] = 1'b0;
        wait_cyc(80);
        chk("zero_end_held", 32'(kp.key_held), 32'd0);

        chk("valid_width", 32'(n_wide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, 16, clock cycles each row is driven before its columns are sampled (min 4).
REQ-002 DEBOUNCE_N, 4, consecutive identical scan frames required to accept a press or a release (min 2).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row_out  output  4  keypad row drive, active-low, exactly one bit low at any time.
REQ-006 col_in  input  4  keypad column sense, active-low (pulled up externally), asynchronous to clk.
REQ-007 key_code  output  4  code of last accepted key, held stable until next acceptance; drives the calculator inkey input.
REQ-008 key_valid  output  1  one-cycle pulse coincident with key_code update.
REQ-009 key_held  output  1  high while an accepted key has not yet been accepted as released.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Row index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles; row_out = ~(1<<index).
REQ-012 Columns SHALL be sampled on the last cycle of each row slot; four slots form one frame (4*SCAN_DIV cycles).
REQ-013 Frame result: exactly one asserted key -> candidate (row,col); zero keys -> NONE; two or more keys -> NONE (ghost rejection).
REQ-014 Keymap (row: col0..col3): r0: 0001,0010,0011,1100(+); r1: 0100,0101,0110,1101; r2: 0111,1000,1001,1011; r3: 1111(C),0000,1110(=),1010.
REQ-015 FSM states IDLE, DEBOUNCE, HELD, RELEASE.
REQ-016 IDLE: candidate present at frame end -> DEBOUNCE, count=1, latch candidate.
REQ-017 DEBOUNCE: same candidate -> count+1; different candidate -> relatch, count=1; NONE -> IDLE.
REQ-018 DEBOUNCE reaching count=DEBOUNCE_N -> HELD; in the cycle after that frame end, key_code<=code, key_valid=1 for exactly one cycle, key_held=1.
REQ-019 HELD: frame result not equal to the held key (NONE, other key, or multi-key) -> RELEASE, count=1; no auto-repeat, no second pulse.
REQ-020 RELEASE: NONE/non-held result -> count+1, reaching DEBOUNCE_N -> IDLE, key_held=0; held key reappears -> HELD, count cleared.
REQ-021 A different key pressed while the first is held SHALL produce no pulse until full release and a new debounce.
REQ-022 Press-to-pulse latency SHALL be at most (DEBOUNCE_N+1)*4*SCAN_DIV+3 cycles.
REQ-023 Counters SHALL saturate at DEBOUNCE_N; row divider wraps at SCAN_DIV-1.

Reset
REQ-024 On rst: row_out=4'b1110, key_code=4'b1111 (C, downstream cleared), key_valid=0, key_held=0, FSM=IDLE, all counters and synchronizer flops 0 (synchronizer flops to 1, idle column level).
REQ-025 rst asserted mid-debounce or mid-hold SHALL discard progress; no pulse SHALL be emitted due to pre-reset activity.

Structure
REQ-026 Shared package keypad_pkg SHALL hold key code constants (KEY_PLUS=1100, KEY_EQ=1110, KEY_CLR=1111, digit codes), the FSM state typedef and the keymap table.
REQ-027 One combinational sub-module keypad_keymap SHALL map (row index, column one-hot) to key code and a multi-key flag.

Verification (SCAN_DIV=4, DEBOUNCE_N=3, frame=16 cycles)
REQ-028 Reset: assert rst 3 cycles -> row_out=1110, key_code=1111, key_valid=0, key_held=0; row_out rotates 1101,1011,0111 every 4 cycles afterwards.
REQ-029 Hold '+' (r0,c3) stable 10 frames -> exactly one key_valid pulse with key_code=1100 within 67 cycles of press; key_held=1 until 3 frames after release.
REQ-030 Bounce '5' (r1,c1) toggling every 5 cycles for 2 frames then stable -> single pulse, key_code=0101.
REQ-031 Press '1' and '2' together 6 frames -> no pulse; release '2' -> one pulse key_code=0001.
REQ-032 Press '=' , assert rst after 2 frames, keep key down -> no pulse before rst; after rst release, pulse key_code=1110 once debounced anew.
REQ-033 Press '0', release 4 frames, press '0' again -> two pulses, both key_code=0000; release shorter than 3 frames -> only one pulse.
